// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// The checksum path is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int CHKSUM_W   = 32;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs an accepted byte stream little-endian into 32-bit words and flags
// each completed word for exactly one cycle after its last byte.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    output logic        last_o
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic        r_valid;

    // Shifting in from the top leaves the first byte in [7:0] after four accepts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (clear_i) begin
                r_cnt  <= '0;
                r_word <= '0;
            end else if (accept_i) begin
                r_word  <= {byte_i, r_word[31:8]};
                r_cnt   <= r_cnt + 2'd1;
                r_valid <= (r_cnt == LAST_IDX);
            end
        end
    end

    assign word_o       = r_word;
    assign word_valid_o = r_valid;
    assign last_o       = (r_cnt == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: zero-fills instruction memory, writes a byte-streamed program
// from address 0, then holds the CPU start line high. Optional checksum
// verification is enabled with IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              busy_o,
    output logic              err_o,
    output logic              start_o
);

    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state,  w_nstate;
    logic [ADDR_W:0]   r_len,    w_nlen;
    logic [ADDR_W-1:0] r_addr,   w_naddr;
    logic [ADDR_W:0]   r_wcount, w_nwcount;
    logic              r_clr_we, w_nclr_we;
    logic              r_wr_en,  w_nwr_en;
    logic              r_ready,  w_nready;
    logic              r_err,    w_nerr;
    logic              r_start,  w_nstart;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [CHKSUM_W-1:0] r_sum, w_nsum;
    logic                r_chk_en, w_nchk_en;
`endif

    logic              w_accept;
    logic              w_word_done;
    logic              w_pk_clear;
    logic              w_start_load;
    logic [ADDR_W:0]   w_wcount_inc;
    logic [31:0]       w_word;
    logic              w_word_valid;
    logic              w_last;

    assign w_accept     = byte_valid_i & r_ready;
    assign w_word_done  = w_accept & w_last;
    assign w_start_load = load_i & ((r_state == ST_IDLE) | (r_state == ST_ERR));
    assign w_wcount_inc = r_wcount + 1'b1;

    byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (w_pk_clear),
        .accept_i     (w_accept),
        .byte_i       (byte_i),
        .word_o       (w_word),
        .word_valid_o (w_word_valid),
        .last_o       (w_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_addr   <= '0;
            r_wcount <= '0;
            r_clr_we <= 1'b0;
            r_wr_en  <= 1'b0;
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_start  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum    <= '0;
            r_chk_en <= 1'b0;
`endif
        end else begin
            r_state  <= w_nstate;
            r_len    <= w_nlen;
            r_addr   <= w_naddr;
            r_wcount <= w_nwcount;
            r_clr_we <= w_nclr_we;
            r_wr_en  <= w_nwr_en;
            r_ready  <= w_nready;
            r_err    <= w_nerr;
            r_start  <= w_nstart;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum    <= w_nsum;
            r_chk_en <= w_nchk_en;
`endif
        end
    end

    // Next-state logic also computes the next value of every registered output,
    // so the final write and the DONE transition land on the same edge.
    always_comb begin
        w_nstate   = r_state;
        w_nlen     = r_len;
        w_naddr    = r_addr;
        w_nwcount  = r_wcount;
        w_nclr_we  = 1'b0;
        w_nwr_en   = 1'b0;
        w_nready   = 1'b0;
        w_nerr     = r_err;
        w_nstart   = 1'b0;
        w_pk_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_nsum     = r_sum;
        w_nchk_en  = 1'b0;
        if (w_word_valid && r_wr_en) begin
            w_nsum = r_sum + w_word;
        end
`endif

        case (r_state)
            ST_CLEAR: begin
                w_nclr_we = 1'b1;
                w_naddr   = r_addr + 1'b1;
                if (r_addr == LAST_ADDR) begin
                    w_nclr_we = 1'b0;
                    w_naddr   = '0;
                    if (r_len != '0) begin
                        w_nstate = ST_LOAD;
                        w_nready = 1'b1;
                    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_nstate = ST_CHK;
                        w_nready = 1'b1;
`else
                        w_nstate = ST_DONE;
`endif
                    end
                end
            end
            ST_LOAD: begin
                w_nready = 1'b1;
                if (w_word_done) begin
                    w_nwr_en  = 1'b1;
                    w_naddr   = r_wcount[ADDR_W-1:0];
                    w_nwcount = w_wcount_inc;
                    if (w_wcount_inc == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_nstate = ST_CHK;
`else
                        w_nstate = ST_DONE;
                        w_nready = 1'b0;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            // The expected sum is compared the cycle after its last byte lands.
            ST_CHK: begin
                w_nready  = r_ready & ~w_word_done;
                w_nchk_en = w_word_done;
                if (r_chk_en && w_word_valid) begin
                    if (w_word == r_sum) begin
                        w_nstate = ST_DONE;
                    end else begin
                        w_nstate = ST_ERR;
                        w_nerr   = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: begin
                w_nstart = 1'b1;
            end
            ST_ERR: begin
                w_nerr = 1'b1;
            end
            default: begin
            end
        endcase

        if (w_start_load) begin
            w_nstate   = ST_CLEAR;
            w_naddr    = '0;
            w_nwcount  = '0;
            w_nclr_we  = 1'b1;
            w_nready   = 1'b0;
            w_pk_clear = 1'b1;
            if (len_i > DEPTH_W) begin
                w_nlen = DEPTH_W;
                w_nerr = 1'b1;
            end else begin
                w_nlen = len_i;
                w_nerr = 1'b0;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_nsum = '0;
`endif
        end
    end

    assign byte_ready_o = r_ready;
    assign imem_we_o    = r_clr_we | (r_wr_en & w_word_valid);
    assign imem_addr_o  = r_addr;
    assign imem_wdata_o = r_wr_en ? w_word : 32'h0;
    assign busy_o       = (r_state == ST_CLEAR) | (r_state == ST_LOAD) | (r_state == ST_CHK);
    assign err_o        = r_err;
    assign start_o      = r_start;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader; expected memory writes are queued by the
// stimulus and popped by an independent write monitor.
module tb_imem_loader;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int WAIT_LIMIT = 3000;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              load_i;
    logic [ADDR_W:0]   len_i;
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_wdata_o;
    logic              busy_o;
    logic              err_o;
    logic              start_o;

    wr_t expQ[$];
    wr_t expWr;
    int  compared   = 0;
    int  mismatched = 0;
    int  cyc        = 0;
    int  lastWeCyc  = 0;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (load_i),
        .len_i        (len_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .start_o      (start_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    // Write monitor: every observed write must match the head of the queue.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && imem_we_o === 1'b1) begin
            lastWeCyc = cyc;
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpectedWrite: got addr=%0h data=%h, required no write",
                         imem_addr_o, imem_wdata_o);
            end else begin
                expWr = expQ.pop_front();
                if (imem_addr_o !== expWr.addr || imem_wdata_o !== expWr.data) begin
                    mismatched++;
                    $display("[TB] FAIL memWrite: got addr=%0h data=%h, required addr=%0h data=%h",
                             imem_addr_o, imem_wdata_o, expWr.addr, expWr.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waits;
        for (int g = 0; g < gap; g++) begin
            byte_valid_i = 1'b0;
            @(negedge clk_i);
        end
        byte_i       = b;
        byte_valid_i = 1'b1;
        waits        = 0;
        while (byte_ready_o !== 1'b1 && waits < WAIT_LIMIT) begin
            @(negedge clk_i);
            waits++;
        end
        if (waits >= WAIT_LIMIT) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL byteReady: got no ready in %0d cycles, required ready", WAIT_LIMIT);
        end
        @(negedge clk_i);
        byte_valid_i = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input int gap);
        applyStimulus(w[7:0],   gap);
        applyStimulus(w[15:8],  gap);
        applyStimulus(w[23:16], gap);
        applyStimulus(w[31:24], gap);
    endtask

    task automatic doReset();
        @(negedge clk_i);
        rst_i        = 1'b1;
        load_i       = 1'b0;
        byte_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        expQ.delete();
    endtask

    task automatic startLoad(input int len);
        load_i = 1'b1;
        len_i  = (ADDR_W + 1)'(len);
        @(negedge clk_i);
        load_i = 1'b0;
    endtask

    task automatic pushWrite(input int addr, input logic [31:0] data);
        wr_t w;
        w.addr = ADDR_W'(addr);
        w.data = data;
        expQ.push_back(w);
    endtask

    task automatic pushClears();
        for (int i = 0; i < DEPTH; i++) pushWrite(i, 32'h0);
    endtask

    task automatic waitStart(output int c);
        int waits;
        waits = 0;
        while (start_o !== 1'b1 && waits < WAIT_LIMIT) begin
            @(negedge clk_i);
            waits++;
        end
        if (waits >= WAIT_LIMIT) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL startTimeout: got start_o=%b after %0d cycles, required 1", start_o, waits);
        end
        c = cyc;
    endtask

    task automatic loadTwoWordProgram(input int gap);
        pushClears();
        pushWrite(0, 32'h00500093);
        pushWrite(1, 32'h00A00113);
        startLoad(2);
        checkOutput("errAfterLoad", 32'(err_o), 32'h0);
        checkOutput("busyInClear", 32'(busy_o), 32'h1);
        sendWord(32'h00500093, gap);
        sendWord(32'h00A00113, gap);
    endtask

    initial begin
        int c;
        int loadCyc;
        logic [31:0] word;
        logic [31:0] sum;

        rst_i        = 1'b1;
        load_i       = 1'b0;
        len_i        = '0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("rstWe",    32'(imem_we_o),    32'h0);
        checkOutput("rstAddr",  32'(imem_addr_o),  32'h0);
        checkOutput("rstWdata", imem_wdata_o,      32'h0);
        checkOutput("rstReady", 32'(byte_ready_o), 32'h0);
        checkOutput("rstBusy",  32'(busy_o),       32'h0);
        checkOutput("rstErr",   32'(err_o),        32'h0);
        checkOutput("rstStart", 32'(start_o),      32'h0);
        rst_i = 1'b0;
        @(negedge clk_i);

        $display("[TB] two-word program, back-to-back bytes");
        loadTwoWordProgram(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendWord(32'h00F001A6, 0);
`endif
        waitStart(c);
`ifndef IMEM_LOADER_CHECKSUM_EN
        checkOutput("startAfterLastWrite", 32'(c - lastWeCyc), 32'h1);
`endif
        checkOutput("doneBusy",  32'(busy_o),       32'h0);
        checkOutput("doneErr",   32'(err_o),        32'h0);
        checkOutput("doneReady", 32'(byte_ready_o), 32'h0);
        checkOutput("pendingWrites1", 32'(expQ.size()), 32'h0);
        startLoad(5);
        repeat (3) @(negedge clk_i);
        checkOutput("doneIgnoresLoadBusy",  32'(busy_o),  32'h0);
        checkOutput("doneIgnoresLoadStart", 32'(start_o), 32'h1);

        $display("[TB] two-word program, byte_valid toggling");
        doReset();
        loadTwoWordProgram(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendWord(32'h00F001A6, 1);
`endif
        waitStart(c);
`ifndef IMEM_LOADER_CHECKSUM_EN
        checkOutput("toggleStartAfterLastWrite", 32'(c - lastWeCyc), 32'h1);
`endif
        checkOutput("toggleBusy", 32'(busy_o), 32'h0);
        checkOutput("pendingWrites2", 32'(expQ.size()), 32'h0);

        $display("[TB] zero-length program");
        doReset();
        pushClears();
        startLoad(0);
        loadCyc = cyc;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendWord(32'h00000000, 0);
`endif
        waitStart(c);
`ifndef IMEM_LOADER_CHECKSUM_EN
        // Cycle n ends at edge n (load edge = 0); start seen after edge k is cycle k+1.
        checkOutput("len0StartCycle", 32'(c - loadCyc + 1), 32'(DEPTH + 2));
`endif
        checkOutput("len0Err", 32'(err_o), 32'h0);
        checkOutput("pendingWrites3", 32'(expQ.size()), 32'h0);

        $display("[TB] oversized length clamps to full memory");
        doReset();
        pushClears();
        sum = 32'h0;
        for (int w = 0; w < DEPTH; w++) begin
            word = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
            pushWrite(w, word);
            sum = sum + word;
        end
        startLoad(300);
        checkOutput("clampErr", 32'(err_o), 32'h1);
        for (int w = 0; w < DEPTH; w++) begin
            sendWord({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 0);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendWord(sum, 0);
`endif
        waitStart(c);
        checkOutput("clampStart", 32'(start_o), 32'h1);
        checkOutput("clampErrSticky", 32'(err_o), 32'h1);
        checkOutput("pendingWrites4", 32'(expQ.size()), 32'h0);

        $display("[TB] reset in the middle of a load");
        doReset();
        pushClears();
        pushWrite(0, 32'h00500093);
        startLoad(2);
        sendWord(32'h00500093, 0);
        applyStimulus(8'h13, 0);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("midRstWe",    32'(imem_we_o),    32'h0);
        checkOutput("midRstAddr",  32'(imem_addr_o),  32'h0);
        checkOutput("midRstWdata", imem_wdata_o,      32'h0);
        checkOutput("midRstReady", 32'(byte_ready_o), 32'h0);
        checkOutput("midRstBusy",  32'(busy_o),       32'h0);
        checkOutput("midRstStart", 32'(start_o),      32'h0);
        checkOutput("pendingWrites5", 32'(expQ.size()), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        pushClears();
        pushWrite(0, 32'hDEADBEEF);
        startLoad(1);
        sendWord(32'hDEADBEEF, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendWord(32'hDEADBEEF, 0);
`endif
        waitStart(c);
        checkOutput("reloadStart", 32'(start_o), 32'h1);
        checkOutput("pendingWrites6", 32'(expQ.size()), 32'h0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        $display("[TB] checksum mismatch");
        doReset();
        loadTwoWordProgram(0);
        sendWord(32'h00000000, 0);
        repeat (4) @(negedge clk_i);
        checkOutput("badSumErr",   32'(err_o),   32'h1);
        checkOutput("badSumStart", 32'(start_o), 32'h0);
        checkOutput("badSumBusy",  32'(busy_o),  32'h0);
        checkOutput("pendingWrites7", 32'(expQ.size()), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
